// File: rtl/arm_alu_arbiter_pkg.sv
// Shared types and constants for the arbitrated ALU block.
//   state_e   : arbiter FSM states
//   alu_op_e  : ARM data-processing opcodes (AND=0000 .. MVN=1111)
//   Flg*      : bit positions inside a {N,Z,C,V} nibble
//   is_arith  : opcodes whose C/V come from the adder rather than being passed through
package arm_alu_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OpAnd = 4'h0, OpEor = 4'h1, OpSub = 4'h2, OpRsb = 4'h3,
    OpAdd = 4'h4, OpAdc = 4'h5, OpSbc = 4'h6, OpRsc = 4'h7,
    OpTst = 4'h8, OpTeq = 4'h9, OpCmp = 4'hA, OpCmn = 4'hB,
    OpOrr = 4'hC, OpMov = 4'hD, OpBic = 4'hE, OpMvn = 4'hF
  } alu_op_e;

  localparam int unsigned FlgN = 3;
  localparam int unsigned FlgZ = 2;
  localparam int unsigned FlgC = 1;
  localparam int unsigned FlgV = 0;

  function automatic logic is_arith(alu_op_e op);
    return (op inside {OpSub, OpRsb, OpAdd, OpAdc, OpSbc, OpRsc, OpCmp, OpCmn});
  endfunction

endpackage

// File: rtl/arm_alu.sv
// Combinational ARM data-processing ALU (no shifter).
//   a_i, b_i  : operands
//   op_i      : 4-bit ARM opcode
//   cin_i     : saved carry, used by ADC/SBC/RSC and passed through as C by logical ops
//   result_o  : result (also produced for TST/TEQ/CMP/CMN)
//   flags_o   : {N,Z,C,V}; logical ops report C=cin_i and V=0
module arm_alu #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             cin_i,
  output logic [Width-1:0] result_o,
  output logic [3:0]       flags_o
);
  import arm_alu_arbiter_pkg::*;

  alu_op_e          op;
  logic [Width-1:0] x, y;
  logic             c_in_add;
  logic [Width:0]   sum;
  logic             arith;

  assign op = alu_op_e'(op_i);

  // All arithmetic ops are x + y + c; subtraction inverts the subtrahend.
  always_comb begin
    x        = a_i;
    y        = b_i;
    c_in_add = 1'b0;
    case (op)
      OpSub, OpCmp: begin y = ~b_i; c_in_add = 1'b1; end
      OpRsb:        begin x = b_i; y = ~a_i; c_in_add = 1'b1; end
      OpAdc:        c_in_add = cin_i;
      OpSbc:        begin y = ~b_i; c_in_add = cin_i; end
      OpRsc:        begin x = b_i; y = ~a_i; c_in_add = cin_i; end
      default:      ;
    endcase
  end

  assign sum   = {1'b0, x} + {1'b0, y} + {{Width{1'b0}}, c_in_add};
  assign arith = is_arith(op);

  always_comb begin
    result_o = sum[Width-1:0];
    case (op)
      OpAnd, OpTst: result_o = a_i & b_i;
      OpEor, OpTeq: result_o = a_i ^ b_i;
      OpOrr:        result_o = a_i | b_i;
      OpMov:        result_o = b_i;
      OpBic:        result_o = a_i & ~b_i;
      OpMvn:        result_o = ~b_i;
      default:      ;
    endcase
  end

  always_comb begin
    flags_o       = '0;
    flags_o[FlgN] = result_o[Width-1];
    flags_o[FlgZ] = (result_o == '0);
    flags_o[FlgC] = arith ? sum[Width] : cin_i;
    flags_o[FlgV] = arith & (x[Width-1] == y[Width-1]) & (sum[Width-1] != x[Width-1]);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr_i, wrapping.
//   req_i      : request vector
//   ptr_i      : index with highest priority this cycle
//   gnt_o      : one-hot grant (all zero when no request)
//   gnt_idx_o  : binary index of the grant
//   gnt_any_o  : some request is granted
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_any_o
);
  int unsigned cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand     = (32'(ptr_i) + i) % NumReq;
      cand_idx = IdxW'(cand);
      if (!gnt_any_o && req_i[cand_idx]) begin
        gnt_any_o       = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        gnt_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/arm_alu_arbiter.sv
// Shares one arm_alu between NUM_REQ requesters with round-robin arbitration.
// One op per grant: IDLE (accept) -> EXEC (compute, capture) -> RESP (hold until taken).
//   req_valid/req_ready : per-requester op handshake; req_ready is one-hot, IDLE only
//   req_a/req_b/req_op  : packed per-requester operands and opcode (slice i = requester i)
//   req_setf            : requester i's saved flags are updated when its op completes
//   rsp_valid/rsp_ready : per-requester response handshake, one-hot rsp_valid
//   rsp_data/rsp_flags  : registered result and {N,Z,C,V} of the completed op
//   flags_q             : saved {N,Z,C,V} per requester; C feeds ADC/SBC/RSC
//   busy                : FSM not idle
module arm_alu_arbiter
  import arm_alu_arbiter_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]         req_op,
  input  logic [NUM_REQ-1:0]           req_setf,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [DATAWIDTH-1:0]         rsp_data,
  output logic [3:0]                   rsp_flags,
  output logic [NUM_REQ*4-1:0]         flags_q,
  output logic                         busy
);

  state_e state_q, state_d;

  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [DATAWIDTH-1:0] a_q, b_q;
  logic [3:0]           op_q;
  logic                 setf_q;
  logic                 cin_q;

  logic [NUM_REQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 accept;
  int unsigned          gsel, qsel;

  logic [DATAWIDTH-1:0] alu_res;
  logic [3:0]           alu_flags;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdxW   (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // The ALU only ever sees latched operands, so requester inputs may change after accept.
  arm_alu #(
    .Width (DATAWIDTH)
  ) u_arm_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .cin_i    (cin_q),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  assign accept = (state_q == StIdle) && gnt_any;
  assign gsel   = 32'(gnt_idx);
  assign qsel   = 32'(gidx_q);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (gnt_any) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready[gidx_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != StIdle);
    if (state_q == StIdle) req_ready = gnt_oh;
    if (state_q == StResp) rsp_valid[gidx_q] = 1'b1;
  end

  // Datapath: op capture on accept, result capture in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      setf_q    <= 1'b0;
      cin_q     <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      flags_q   <= '0;
    end else begin
      if (accept) begin
        gidx_q   <= gnt_idx;
        a_q      <= req_a[gsel*DATAWIDTH +: DATAWIDTH];
        b_q      <= req_b[gsel*DATAWIDTH +: DATAWIDTH];
        op_q     <= req_op[gsel*4 +: 4];
        setf_q   <= req_setf[gnt_idx];
        cin_q    <= flags_q[gsel*4 + FlgC];
        rr_ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == StExec) begin
        rsp_data  <= alu_res;
        rsp_flags <= alu_flags;
        if (setf_q) flags_q[qsel*4 +: 4] <= alu_flags;
      end
    end
  end

endmodule
